keccak_rho_inv_seq: RTL and testbench

KECCAK_RHO_INV_SEQ -- requirements
Module: keccak_rho_inv_seq

---
 rtl/keccak_rho_inv_seq.sv | 134 +++++++++++++
 tb/tb_keccak_rho_inv_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_rho_inv_seq.sv
// keccak_rho_inv_seq: sequential inverse Keccak rho, one lane per cycle.
// Ports: clk, rst_n (async low), in_valid/in_ready/state_in accept a
// 1600-bit state; out_valid/out_ready/state_out return it; busy flags
// lane processing. Define KECCAK_RHO_DIR_SEL_EN to add input dir
// (0 = inverse rho, 1 = forward rho), sampled on accept.
module keccak_rho_inv_seq (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1599:0] state_in,
`ifdef KECCAK_RHO_DIR_SEL_EN
   input  logic          dir,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1599:0] state_out,
   output logic          busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [4:0] LAST = 5'd24;

   logic [1:0]    fsm;
   logic [4:0]    cnt;
   logic [1599:0] st;
   logic [63:0]   lane;
   logic [63:0]   rot;
   logic [5:0]    off;
   logic [5:0]    amt;
   logic          cnt_ok;
   logic          accept;

   function automatic logic [5:0] rho_off(input logic [4:0] i);
      logic [5:0] r;
      case (i)
         5'd0:  r = 6'd0;
         5'd1:  r = 6'd1;
         5'd2:  r = 6'd62;
         5'd3:  r = 6'd28;
         5'd4:  r = 6'd27;
         5'd5:  r = 6'd36;
         5'd6:  r = 6'd44;
         5'd7:  r = 6'd6;
         5'd8:  r = 6'd55;
         5'd9:  r = 6'd20;
         5'd10: r = 6'd3;
         5'd11: r = 6'd10;
         5'd12: r = 6'd43;
         5'd13: r = 6'd25;
         5'd14: r = 6'd39;
         5'd15: r = 6'd41;
         5'd16: r = 6'd45;
         5'd17: r = 6'd15;
         5'd18: r = 6'd21;
         5'd19: r = 6'd8;
         5'd20: r = 6'd18;
         5'd21: r = 6'd2;
         5'd22: r = 6'd61;
         5'd23: r = 6'd56;
         5'd24: r = 6'd14;
         default: r = 6'd0;
      endcase
      return r;
   endfunction

`ifdef KECCAK_RHO_DIR_SEL_EN
   logic dir_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dir_q <= 1'b0;
      else if (accept)
         dir_q <= dir;
   end
   // left rotate by r is a right rotate by (64 - r) mod 64
   assign amt = dir_q ? 6'(6'd0 - off) : off;
`else
   assign amt = off;
`endif

   assign cnt_ok    = (cnt <= LAST);
   assign accept    = in_valid && (fsm == IDLE);
   assign off       = rho_off(cnt);
   assign lane      = cnt_ok ? st[{cnt, 6'd0} +: 64] : 64'd0;
   // shifting by 64 yields zero, so amt = 0 passes the lane through
   assign rot       = (lane >> amt) | (lane << (7'd64 - {1'b0, amt}));

   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm == BUSY);
   assign state_out = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm <= IDLE;
         cnt <= 5'd0;
         st  <= '0;
      end else if (!cnt_ok) begin
         fsm <= IDLE;
         cnt <= 5'd0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  st  <= state_in;
                  cnt <= 5'd0;
                  fsm <= BUSY;
               end
            end
            BUSY: begin
               st[{cnt, 6'd0} +: 64] <= rot;
               if (cnt == LAST) begin
                  cnt <= 5'd0;
                  fsm <= DONE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DONE: begin
               if (out_ready)
                  fsm <= IDLE;
            end
            default: begin
               fsm <= IDLE;
               cnt <= 5'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_rho_inv_seq.sv
// tb_keccak_rho_inv_seq: randomized check of keccak_rho_inv_seq against
// a bit-level rho model.
module tb_keccak_rho_inv_seq;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1599:0] state_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1599:0] state_out;
   logic          busy;
   logic          dir = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   keccak_rho_inv_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
`ifdef KECCAK_RHO_DIR_SEL_EN
      .dir       (dir),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // rho offsets indexed [y][x]
   int rtab [5][5] = '{
      '{ 0,  1, 62, 28, 27},
      '{36, 44,  6, 55, 20},
      '{ 3, 10, 43, 25, 39},
      '{41, 45, 15, 21,  8},
      '{18,  2, 61, 56, 14}
   };

   function automatic logic [1599:0] rho_fwd(input logic [1599:0] s);
      logic [1599:0] o;
      o = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            for (int j = 0; j < 64; j++)
               o[64*(x+5*y) + (j+rtab[y][x])%64] = s[64*(x+5*y) + j];
      return o;
   endfunction

   function automatic logic [1599:0] rho_inv(input logic [1599:0] s);
      logic [1599:0] o;
      o = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            for (int j = 0; j < 64; j++)
               o[64*(x+5*y) + j] = s[64*(x+5*y) + (j+rtab[y][x])%64];
      return o;
   endfunction

   function automatic logic [1599:0] rand_state();
      logic [1599:0] s;
      for (int k = 0; k < 50; k++)
         s[32*k +: 32] = $urandom;
      return s;
   endfunction

   task automatic check(input string tag, input logic [1599:0] got,
                        input logic [1599:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag,
                  got[255:0], exp[255:0]);
      end
   endtask

   // send s, wait for result, compare, then consume
   task automatic xfer(input string tag, input logic [1599:0] s,
                       input logic [1599:0] exp, input int want_lat);
      int lat;
      @(negedge clk);
      check({tag, "_rdy"}, 1600'(in_ready), 1600'(1));
      in_valid = 1'b1;
      state_in = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (want_lat > 0)
         check({tag, "_lat"}, 1600'(lat), 1600'(want_lat));
      check(tag, state_out, exp);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   logic [1599:0] s;
   logic [1599:0] held;

   initial begin
      #2;
      check("rst_rdy", 1600'(in_ready), 1600'(1));
      check("rst_ov", 1600'(out_valid), 1600'(0));
      check("rst_busy", 1600'(busy), 1600'(0));
      check("rst_st", state_out, '0);
      @(negedge clk);
      rst_n = 1'b1;

      s = '0;
      s[127:64] = 64'h2;
      xfer("lane1", s, rho_inv(s), 25);
      check("lane1_val", 1600'(state_out[127:64]), 1600'(64'h1));

      s = '0;
      s[191:128] = 64'h1;
      s[63:0]    = 64'hDEADBEEFCAFEF00D;
      xfer("lane2", s, rho_inv(s), 25);
      check("lane2_val", 1600'(state_out[191:128]), 1600'(64'h4));
      check("lane0_val", 1600'(state_out[63:0]),
            1600'(64'hDEADBEEFCAFEF00D));

      for (int t = 0; t < 1000; t++) begin
         s = rand_state();
         xfer("rand", rho_fwd(s), s, (t < 5) ? 25 : 0);
      end

      // stall in DONE with stray in_valid pulses
      s = rand_state();
      @(negedge clk);
      in_valid = 1'b1;
      state_in = s;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 30 && !out_valid; k++) @(negedge clk);
      check("stall_ov0", 1600'(out_valid), 1600'(1));
      held = rho_inv(s);
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         state_in = rand_state();
         check("stall_ov", 1600'(out_valid), 1600'(1));
         check("stall_rdy", 1600'(in_ready), 1600'(0));
         check("stall_st", state_out, held);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("stall_end", state_out, held);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("stall_idle", 1600'(in_ready), 1600'(1));

      // reset mid-transform
      s = rand_state();
      @(negedge clk);
      in_valid = 1'b1;
      state_in = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      check("mid_busy", 1600'(busy), 1600'(1));
      rst_n = 1'b0;
      #1;
      check("arst_rdy", 1600'(in_ready), 1600'(1));
      check("arst_ov", 1600'(out_valid), 1600'(0));
      check("arst_busy", 1600'(busy), 1600'(0));
      check("arst_st", state_out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      s = rand_state();
      xfer("post_rst", rho_fwd(s), s, 25);

`ifdef KECCAK_RHO_DIR_SEL_EN
      s = '0;
      s[127:64] = 64'h1;
      dir = 1'b1;
      xfer("fwd", s, rho_fwd(s), 25);
      check("fwd_val", 1600'(state_out[127:64]), 1600'(64'h2));
      // back-to-back: new state accepted on the cycle after consume
      s = rand_state();
      xfer("fwd_b2b", s, rho_fwd(s), 25);
      dir = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
